fc_outneuron_writer: RTL and testbench
======================================

FC_OUTNEURON_WRITER -- requirements
Module: fc_outneuron_writer

Interface
REQ-001 Parameter PO, default `PO, output neurons per accumulation group (lanes).
REQ-002 Parameter OUTNEURON, default `OUTNEURON, total output neurons per layer; multiple of PO.
REQ-003 Parameter ACCUM_DATA_WIDTH_FC, default `ACCUM_DATA_WIDTH_FC, signed accumulator width per lane.
REQ-004 Parameter DATA_WIDTH_FC, default `DATA_WIDTH_FC, signed stored neuron width.
REQ-005 Parameter FC_OUTNEURON_ADDR_WIDTH, default `FC_OUTNEURON_ADDR_WIDTH, output RAM address width.
REQ-006 Parameter FRAC_SHIFT, default 8, arithmetic right shift applied to each accumulator.
REQ-007 Parameter RELU_EN, default 1, 1 clamps negative results to zero.
REQ-008 clock  in  1  single clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 start  in  1  one-cycle pulse; clears group/lane counters and done, begins a layer.
REQ-011 accum_valid  in  1  one-cycle pulse; accum_result_all holds PO finished sums.
REQ-012 accum_result_all  in  ACCUM_DATA_WIDTH_FC*PO  lane k at bits [k*W+W-1:k*W].
REQ-013 out_neuron_address  out  FC_OUTNEURON_ADDR_WIDTH  output RAM write address.
REQ-014 out_neuron_data  out  DATA_WIDTH_FC  quantised neuron value.
REQ-015 out_neuron_wren  out  1  output RAM write enable.
REQ-016 busy  out  1  high while buffered lanes remain to be written.
REQ-017 overrun  out  1  sticky: accum_valid arrived while busy.
REQ-018 done  out  1  sticky: all OUTNEURON values written.

Function
REQ-019 FSM states IDLE, WAIT_ACC, DRAIN, FINISH; IDLE->WAIT_ACC on start.
REQ-020 WAIT_ACC: on accum_valid, register all PO lanes into a capture buffer and go to DRAIN next cycle.
REQ-021 DRAIN: write one lane per cycle, lane 0 first, out_neuron_wren=1 each DRAIN cycle, exactly PO writes per group.
REQ-022 Address = group*PO + lane; group counts 0..OUTNEURON/PO-1.
REQ-023 Data path per lane: arithmetic shift right by FRAC_SHIFT; if RELU_EN and negative then 0; saturate to [-2^(DATA_WIDTH_FC-1), 2^(DATA_WIDTH_FC-1)-1].
REQ-024 Write latency: first write cycle is the 2nd rising edge after the accum_valid edge; address/data/wren registered.
REQ-025 After lane PO-1: if group was last, go FINISH; else group+1 and return to WAIT_ACC.
REQ-026 FINISH: done=1, wren=0, go IDLE; done holds until start or reset.
REQ-027 accum_valid while busy: overrun set, new data ignored, drain of current group continues unaffected.
REQ-028 accum_valid in IDLE or FINISH ignored, no flag.
REQ-029 start while busy or in WAIT_ACC: abort, counters to 0, done=0, overrun kept, enter WAIT_ACC; start has priority over accum_valid in the same cycle.
REQ-030 busy=1 exactly in DRAIN.

Reset
REQ-031 Reset (sync) forces IDLE, group=0, lane=0, out_neuron_address=0, out_neuron_data=0, out_neuron_wren=0, busy=0, overrun=0, done=0, buffer=0.
REQ-032 Reset mid-DRAIN: no further write after the reset edge.

Structure
REQ-033 Widths, PO, OUTNEURON and FSM state encoding come from the shared fc_param_1 header; FRAC_SHIFT and RELU_EN added there.
REQ-034 Per-lane shift/ReLU/saturate is one sub-module fc_quantize_relu, instantiated once on the selected lane.

Verification
REQ-035 PO=2, OUTNEURON=4, FRAC_SHIFT=8: start; accum_valid with lanes {0x0300, 0x0500} -> writes addr0=3, addr1=5 on consecutive cycles, second edge after pulse.
REQ-036 Lane value -0x0400 with RELU_EN=1 -> data 0; RELU_EN=0 -> data -4.
REQ-037 Lane value 0x7FFFFF00 with DATA_WIDTH_FC=16 -> data 0x7FFF; 0x80000000 with RELU_EN=0 -> 0x8000.
REQ-038 Two groups back-to-back -> addresses 0,1,2,3; done rises the cycle after addr 3 write.
REQ-039 accum_valid during DRAIN -> overrun=1, write sequence unchanged; start then reset clears counters, reset clears overrun.
REQ-040 Reset asserted after first write of a group -> wren=0 from next edge, all outputs at reset values.

Source files
------------

// File: rtl/fc_outneuron_writer_pkg.sv
// Shared FC output-layer parameters and the output writer FSM encoding.
package fc_outneuron_writer_pkg;

  localparam int FC_PO                      = 2;
  localparam int FC_OUTNEURON               = 4;
  localparam int FC_ACCUM_DATA_WIDTH        = 32;
  localparam int FC_DATA_WIDTH              = 16;
  localparam int FC_OUTNEURON_ADDR_WIDTH    = 8;
  localparam int FC_FRAC_SHIFT              = 8;
  localparam int FC_RELU_EN                 = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACC = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_FINISH   = 2'd3
  } fc_writer_state_e;

endpackage

// File: rtl/fc_outneuron_writer_quantize_relu.sv
// Per-lane quantiser: arithmetic shift, optional ReLU, saturation to the stored neuron width.
module fc_quantize_relu #(
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU_EN    = 1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] q
);

  // Saturation bounds sign-extended to accumulator width; assumes ACC_W >= DATA_W.
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> FRAC_SHIFT;

  // NOTE: q gets a default before any branch so this block can never infer a latch.
  always_comb begin
    q = shifted[DATA_W-1:0];
    if ((RELU_EN != 0) && (shifted < 0)) begin
      q = '0;
    end else if (shifted > MAX_V) begin
      q = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      q = MIN_V[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fc_outneuron_writer.sv
// Captures PO accumulator lanes per group and writes them, one per cycle, as quantised neurons.
module fc_outneuron_writer
  import fc_outneuron_writer_pkg::*;
#(
  parameter int PO                      = FC_PO,
  parameter int OUTNEURON               = FC_OUTNEURON,
  parameter int ACCUM_DATA_WIDTH_FC     = FC_ACCUM_DATA_WIDTH,
  parameter int DATA_WIDTH_FC           = FC_DATA_WIDTH,
  parameter int FC_OUTNEURON_ADDR_WIDTH = fc_outneuron_writer_pkg::FC_OUTNEURON_ADDR_WIDTH,
  parameter int FRAC_SHIFT              = FC_FRAC_SHIFT,
  parameter int RELU_EN                 = FC_RELU_EN
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  accum_valid,
  input  logic [ACCUM_DATA_WIDTH_FC*PO-1:0]     accum_result_all,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]    out_neuron_address,
  output logic [DATA_WIDTH_FC-1:0]              out_neuron_data,
  output logic                                  out_neuron_wren,
  output logic                                  busy,
  output logic                                  overrun,
  output logic                                  done
);

  localparam int GROUPS = OUTNEURON / PO;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW     = (PO > 1) ? $clog2(PO) : 1;
  localparam int AW     = FC_OUTNEURON_ADDR_WIDTH;

  fc_writer_state_e                          state;
  logic [GW-1:0]                             group;
  logic [LW-1:0]                             lane;
  logic [PO-1:0][ACCUM_DATA_WIDTH_FC-1:0]    cap_buf;
  logic signed [DATA_WIDTH_FC-1:0]           lane_q;

  fc_quantize_relu #(
    .ACC_W      (ACCUM_DATA_WIDTH_FC),
    .DATA_W     (DATA_WIDTH_FC),
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_quant (
    .acc (cap_buf[lane]),
    .q   (lane_q)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ST_IDLE;
      group              <= '0;
      lane               <= '0;
      // NOTE: the capture buffer is a small register bank, so it is cleared on reset like any flop.
      cap_buf            <= '0;
      out_neuron_address <= '0;
      out_neuron_data    <= '0;
      out_neuron_wren    <= 1'b0;
      busy               <= 1'b0;
      overrun            <= 1'b0;
      done               <= 1'b0;
    end else begin
      out_neuron_wren <= 1'b0;
      if (start) begin
        // Start also aborts a layer in progress; accum_valid in the same cycle is dropped.
        state <= ST_WAIT_ACC;
        group <= '0;
        lane  <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_WAIT_ACC: begin
            if (accum_valid) begin
              cap_buf <= accum_result_all;
              lane    <= '0;
              busy    <= 1'b1;
              state   <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (accum_valid) overrun <= 1'b1;
            out_neuron_wren    <= 1'b1;
            out_neuron_address <= AW'(group) * AW'(PO) + AW'(lane);
            out_neuron_data    <= lane_q;
            if (lane == LW'(PO - 1)) begin
              lane <= '0;
              busy <= 1'b0;
              if (group == GW'(GROUPS - 1)) begin
                state <= ST_FINISH;
              end else begin
                group <= group + 1'b1;
                state <= ST_WAIT_ACC;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
          ST_FINISH: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_outneuron_writer.sv
// Directed bench: a ReLU and a linear writer share stimulus; expected values are hand-computed.
module tb_fc_outneuron_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        accum_valid = 1'b0;
  logic [63:0] accum_result_all = '0;

  logic [7:0]  addr_r,  addr_l;
  logic [15:0] data_r,  data_l;
  logic        wren_r,  wren_l;
  logic        busy_r,  busy_l;
  logic        ovr_r,   ovr_l;
  logic        done_r,  done_l;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fc_outneuron_writer #(
    .PO(2), .OUTNEURON(4), .ACCUM_DATA_WIDTH_FC(32), .DATA_WIDTH_FC(16),
    .FC_OUTNEURON_ADDR_WIDTH(8), .FRAC_SHIFT(8), .RELU_EN(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .accum_valid(accum_valid),
    .accum_result_all(accum_result_all), .out_neuron_address(addr_r),
    .out_neuron_data(data_r), .out_neuron_wren(wren_r), .busy(busy_r),
    .overrun(ovr_r), .done(done_r)
  );

  fc_outneuron_writer #(
    .PO(2), .OUTNEURON(4), .ACCUM_DATA_WIDTH_FC(32), .DATA_WIDTH_FC(16),
    .FC_OUTNEURON_ADDR_WIDTH(8), .FRAC_SHIFT(8), .RELU_EN(0)
  ) dut_lin (
    .clock(clock), .reset(reset), .start(start), .accum_valid(accum_valid),
    .accum_result_all(accum_result_all), .out_neuron_address(addr_l),
    .out_neuron_data(data_l), .out_neuron_wren(wren_l), .busy(busy_l),
    .overrun(ovr_l), .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_acc(input logic [31:0] lane0, input logic [31:0] lane1);
    accum_valid      = 1'b1;
    accum_result_all = {lane1, lane0};
    tick();
    accum_valid      = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [7:0] a,
                             input logic [15:0] d_relu, input logic [15:0] d_lin);
    check({tag, "_wren"},  32'(wren_r), 32'd1);
    check({tag, "_addr"},  32'(addr_r), 32'(a));
    check({tag, "_data"},  32'(data_r), 32'(d_relu));
    check({tag, "_dlin"},  32'(data_l), 32'(d_lin));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(addr_r), 32'd0);
    check({tag, "_data"},  32'(data_r), 32'd0);
    check({tag, "_wren"},  32'(wren_r), 32'd0);
    check({tag, "_busy"},  32'(busy_r), 32'd0);
    check({tag, "_ovr"},   32'(ovr_r),  32'd0);
    check({tag, "_done"},  32'(done_r), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Layer 1: two groups back-to-back, ReLU and saturation cases in group 1.
    pulse_start();
    pulse_acc(32'h0000_0300, 32'h0000_0500);
    check("g0_nowrite_yet", 32'(wren_r), 32'd0);
    check("g0_busy",        32'(busy_r), 32'd1);
    tick();
    check_write("g0_l0", 8'd0, 16'h0003, 16'h0003);
    tick();
    check_write("g0_l1", 8'd1, 16'h0005, 16'h0005);
    check("g0_busy_off",    32'(busy_r), 32'd0);
    tick();
    check("g0_gap_wren",    32'(wren_r), 32'd0);
    pulse_acc(32'hFFFF_FC00, 32'h7FFF_FF00);
    tick();
    check_write("g1_l0", 8'd2, 16'h0000, 16'hFFFC);
    tick();
    check_write("g1_l1", 8'd3, 16'h7FFF, 16'h7FFF);
    check("g1_done_early",  32'(done_r), 32'd0);
    tick();
    check("fin_done",       32'(done_r), 32'd1);
    check("fin_wren",       32'(wren_r), 32'd0);
    pulse_acc(32'h0000_0100, 32'h0000_0100);
    check("idle_acc_ovr",   32'(ovr_r),  32'd0);
    check("idle_done_hold", 32'(done_r), 32'd1);
    tick();
    check("idle_acc_wren",  32'(wren_r), 32'd0);

    // Layer 2: negative saturation and overrun during DRAIN.
    pulse_start();
    check("start_clr_done", 32'(done_r), 32'd0);
    pulse_acc(32'h8000_0000, 32'h0000_0100);
    pulse_acc(32'h2222_0000, 32'h1111_0000);
    check_write("ovr_l0", 8'd0, 16'h0000, 16'h8000);
    check("ovr_set",        32'(ovr_r),  32'd1);
    tick();
    check_write("ovr_l1", 8'd1, 16'h0001, 16'h0001);
    tick();

    // Restart in WAIT_ACC of group 1: counters back to 0, overrun kept.
    pulse_start();
    check("restart_ovr",    32'(ovr_r),  32'd1);
    pulse_acc(32'h0000_0200, 32'h0000_0A00);
    tick();
    check_write("restart_l0", 8'd0, 16'h0002, 16'h0002);

    // Reset after the first write of a group.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("mid_rst");
    tick();
    check("post_rst_wren",  32'(wren_r), 32'd0);

    // Start during DRAIN aborts the group with no further write.
    pulse_start();
    pulse_acc(32'h0000_0300, 32'h0000_0400);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_wren",     32'(wren_r), 32'd0);
    check("abort_busy",     32'(busy_r), 32'd0);
    pulse_acc(32'h0000_0700, 32'h0000_0600);
    tick();
    check_write("abort_l0", 8'd0, 16'h0007, 16'h0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
